// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out sequencer.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Counter width for a count of n; never below 1 so a zero-length range still gets a real register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register; out_bit always presents the next bit to be emitted.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             out_bit
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) sr <= {sr[WIDTH-2:0], 1'b0};
      else                sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign out_bit = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/piso_sched.sv
// Load/shift sequencer: accepts a word on valid/ready, emits it one bit per bit_tick with framing and guard gap.
module piso_sched
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             bit_tick,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output state_t           state
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  // Handshake: a word transfers on any posedge where pi_valid and pi_ready are both high;
  // pi_ready depends only on state, never on pi_valid.
  logic          accept;
  logic          shift_en;
  logic          head;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;

  assign pi_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = pi_valid & pi_ready;
  assign shift_en = (state == ST_SHIFT) & bit_tick;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data (pi_data),
    .shift_en  (shift_en),
    .out_bit   (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      so          <= 1'b0;
      so_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      so_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_tick) begin
            so          <= head;
            so_valid    <= 1'b1;
            frame_start <= (bit_cnt == '0);
            if (bit_cnt == BIT_LAST) begin
              frame_end <= 1'b1;
              bit_cnt   <= '0;
              gap_cnt   <= '0;
              state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          // so keeps the last data bit through the guard interval.
          if (bit_tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_sched.sv
// Bench for piso_sched: four configurations run side by side against a tick-count reference model.
module tb_piso_sched;
  import piso_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] valid_v, tick_v, ready_v, so_v, sv_v, fs_v, fe_v, busy_v;
  logic [3:0] data_v [4];
  state_t     st_v [4];

  int errors = 0;
  int checks = 0;

  // Configurations: 0 = W4/G0/MSB, 1 = W4/G0/LSB, 2 = W4/G2/MSB, 3 = W2/G0/MSB.
  piso_sched #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .pi_valid(valid_v[0]), .pi_ready(ready_v[0]), .pi_data(data_v[0]),
    .bit_tick(tick_v[0]), .so(so_v[0]), .so_valid(sv_v[0]), .frame_start(fs_v[0]),
    .frame_end(fe_v[0]), .busy(busy_v[0]), .state(st_v[0]));
  piso_sched #(.WIDTH(4), .GAP(0), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset(reset), .pi_valid(valid_v[1]), .pi_ready(ready_v[1]), .pi_data(data_v[1]),
    .bit_tick(tick_v[1]), .so(so_v[1]), .so_valid(sv_v[1]), .frame_start(fs_v[1]),
    .frame_end(fe_v[1]), .busy(busy_v[1]), .state(st_v[1]));
  piso_sched #(.WIDTH(4), .GAP(2), .MSB_FIRST(1)) u2 (
    .clk(clk), .reset(reset), .pi_valid(valid_v[2]), .pi_ready(ready_v[2]), .pi_data(data_v[2]),
    .bit_tick(tick_v[2]), .so(so_v[2]), .so_valid(sv_v[2]), .frame_start(fs_v[2]),
    .frame_end(fe_v[2]), .busy(busy_v[2]), .state(st_v[2]));
  piso_sched #(.WIDTH(2), .GAP(0), .MSB_FIRST(1)) u3 (
    .clk(clk), .reset(reset), .pi_valid(valid_v[3]), .pi_ready(ready_v[3]), .pi_data(data_v[3][1:0]),
    .bit_tick(tick_v[3]), .so(so_v[3]), .so_valid(sv_v[3]), .frame_start(fs_v[3]),
    .frame_end(fe_v[3]), .busy(busy_v[3]), .state(st_v[3]));

  function automatic int cfg_w(input int i);
    return (i == 3) ? 2 : 4;
  endfunction
  function automatic int cfg_g(input int i);
    return (i == 2) ? 2 : 0;
  endfunction
  function automatic int cfg_m(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  // Reference: a word costs WIDTH+GAP ticks; tick number k < WIDTH carries data bit k of the order.
  int         m_left [4];
  logic [3:0] m_word [4];
  logic [3:0] m_so, m_sv, m_fs, m_fe;

  function automatic int tick_no(input int i);
    return cfg_w(i) + cfg_g(i) - m_left[i];
  endfunction
  function automatic logic model_bit(input int i, input int k);
    return (cfg_m(i) != 0) ? m_word[i][cfg_w(i) - 1 - k] : m_word[i][k];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_left[i] <= 0;
        m_word[i] <= '0;
        m_so[i] <= 1'b0; m_sv[i] <= 1'b0; m_fs[i] <= 1'b0; m_fe[i] <= 1'b0;
      end else begin
        m_sv[i] <= 1'b0; m_fs[i] <= 1'b0; m_fe[i] <= 1'b0;
        if (m_left[i] == 0) begin
          if (valid_v[i]) begin
            m_left[i] <= cfg_w(i) + cfg_g(i);
            m_word[i] <= data_v[i] & 4'((1 << cfg_w(i)) - 1);
          end
        end else if (tick_v[i]) begin
          if (tick_no(i) < cfg_w(i)) begin
            m_so[i] <= model_bit(i, tick_no(i));
            m_sv[i] <= 1'b1;
            m_fs[i] <= (tick_no(i) == 0);
            m_fe[i] <= (tick_no(i) == cfg_w(i) - 1);
          end
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: wait for the falling edge, then compare every instance against the model.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("so[%0d]", i), 32'(so_v[i]), 32'(m_so[i]));
      chk($sformatf("so_valid[%0d]", i), 32'(sv_v[i]), 32'(m_sv[i]));
      chk($sformatf("frame_start[%0d]", i), 32'(fs_v[i]), 32'(m_fs[i]));
      chk($sformatf("frame_end[%0d]", i), 32'(fe_v[i]), 32'(m_fe[i]));
      chk($sformatf("pi_ready[%0d]", i), 32'(ready_v[i]), 32'(m_left[i] == 0));
      chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_left[i] != 0));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [15:0] c_bits;
  int          c_nb;
  int          c_fs[$];
  int          c_fe[$];

  task automatic clear_col();
    c_bits = '0;
    c_nb   = 0;
    c_fs.delete();
    c_fe.delete();
  endtask

  task automatic col(input int i, input int c);
    if (sv_v[i]) begin
      c_bits = {c_bits[14:0], so_v[i]};
      c_nb++;
    end
    if (fs_v[i]) c_fs.push_back(c);
    if (fe_v[i]) c_fe.push_back(c);
  endtask

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic       tick;
    logic       so;
    logic       sv;
    logic       fs;
    logic       fe;
    logic       ready;
  } vec_t;

  vec_t tbl [6];

  initial begin
    reset = 1'b1;
    valid_v = 4'hF;
    tick_v  = 4'hF;
    for (int i = 0; i < 4; i++) data_v[i] = 4'($urandom_range(0, 15));

    // Reset with pi_valid held high: quiet outputs, ready immediately afterwards.
    step();
    step();
    chk("rst_so", 32'(so_v), 32'h0);
    chk("rst_so_valid", 32'(sv_v), 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    reset = 1'b0;
    chk("post_rst_ready", 32'(ready_v), 32'hF);
    step();
    chk("post_rst_accept", 32'(busy_v), 32'hF);
    valid_v = 4'h0;
    repeat (10) step();

    // Cycle-exact vectors on the W4/G0/MSB-first instance, tick tied high.
    tbl[0] = '{1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      valid_v[0] = tbl[k].valid;
      data_v[0]  = tbl[k].data;
      tick_v[0]  = tbl[k].tick;
      step();
      chk($sformatf("tbl%0d_so", k), 32'(so_v[0]), 32'(tbl[k].so));
      chk($sformatf("tbl%0d_so_valid", k), 32'(sv_v[0]), 32'(tbl[k].sv));
      chk($sformatf("tbl%0d_frame_start", k), 32'(fs_v[0]), 32'(tbl[k].fs));
      chk($sformatf("tbl%0d_frame_end", k), 32'(fe_v[0]), 32'(tbl[k].fe));
      chk($sformatf("tbl%0d_pi_ready", k), 32'(ready_v[0]), 32'(tbl[k].ready));
    end

    // LSB-first with a tick every third cycle.
    valid_v = 4'h0;
    tick_v  = 4'h0;
    valid_v[1] = 1'b1;
    data_v[1]  = 4'b1011;
    step();
    valid_v[1] = 1'b0;
    clear_col();
    for (int c = 1; c <= 15; c++) begin
      tick_v[1] = (c % 3 == 0);
      step();
      col(1, c);
    end
    chk("lsb_bits", 32'(c_bits), 32'h000D);
    chk("lsb_nbits", 32'(c_nb), 32'd4);
    chk("lsb_fe_count", 32'(c_fe.size()), 32'd1);
    if (c_fe.size() > 0) chk("lsb_fe_cycle", 32'(c_fe[0]), 32'd12);

    // GAP=2, back-to-back words with pi_valid held high.
    tick_v = 4'hF;
    valid_v[2] = 1'b1;
    data_v[2]  = 4'hA;
    step();
    data_v[2] = 4'h5;
    clear_col();
    for (int c = 1; c <= 15; c++) begin
      step();
      col(2, c);
      if (c == 7) valid_v[2] = 1'b0;
    end
    chk("gap_bits", 32'(c_bits), 32'h00A5);
    chk("gap_nbits", 32'(c_nb), 32'd8);
    chk("gap_fs_count", 32'(c_fs.size()), 32'd2);
    if (c_fs.size() > 1) chk("gap_word_spacing", 32'(c_fs[1] - c_fs[0]), 32'd7);

    // Reset after two bits of 4'hF, then a clean 4'h3.
    valid_v[0] = 1'b1;
    data_v[0]  = 4'hF;
    step();
    valid_v[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("midrst_so", 32'(so_v), 32'h0);
    chk("midrst_so_valid", 32'(sv_v), 32'h0);
    chk("midrst_frame_end", 32'(fe_v), 32'h0);
    chk("midrst_busy", 32'(busy_v), 32'h0);
    reset = 1'b0;
    valid_v[0] = 1'b1;
    data_v[0]  = 4'h3;
    step();
    valid_v[0] = 1'b0;
    clear_col();
    for (int c = 1; c <= 6; c++) begin
      step();
      col(0, c);
    end
    chk("after_rst_bits", 32'(c_bits), 32'h0003);
    chk("after_rst_nbits", 32'(c_nb), 32'd4);

    // pi_data changing mid-frame must not disturb the word in flight.
    valid_v[0] = 1'b1;
    data_v[0]  = 4'h9;
    step();
    valid_v[0] = 1'b0;
    data_v[0]  = 4'h6;
    clear_col();
    for (int c = 1; c <= 6; c++) begin
      step();
      col(0, c);
    end
    chk("hold_data_bits", 32'(c_bits), 32'h0009);
    chk("hold_data_nbits", 32'(c_nb), 32'd4);

    // WIDTH=2: framing on consecutive ticks.
    valid_v[3] = 1'b1;
    data_v[3]  = 4'b0010;
    step();
    valid_v[3] = 1'b0;
    clear_col();
    for (int c = 1; c <= 4; c++) begin
      step();
      col(3, c);
    end
    chk("w2_bits", 32'(c_bits), 32'h0002);
    chk("w2_nbits", 32'(c_nb), 32'd2);
    chk("w2_fs_count", 32'(c_fs.size()), 32'd1);
    chk("w2_fe_count", 32'(c_fe.size()), 32'd1);
    if (c_fs.size() > 0) chk("w2_fs_cycle", 32'(c_fs[0]), 32'd1);
    if (c_fe.size() > 0) chk("w2_fe_cycle", 32'(c_fe[0]), 32'd2);

    // Random traffic, alternating between sparse ticks and tick tied high, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        valid_v[i] = ($urandom_range(0, 3) != 0);
        data_v[i]  = 4'($urandom_range(0, 15));
        tick_v[i]  = ((n / 500) % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset   = 1'b0;
    valid_v = 4'h0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
